// File: rtl/mux2x1_rr_arbiter.sv
// Two-requester round-robin arbiter with bounded bursts feeding a registered 2:1 mux.
// The current owner is exported on sel_o. The output word is held stable while stalled.
module mux2x1_rr_arbiter #(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned MAX_BURST = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             in0_valid_i,
    input  logic [WIDTH-1:0] in0_data_i,
    output logic             in0_ready_o,
    input  logic             in1_valid_i,
    input  logic [WIDTH-1:0] in1_data_i,
    output logic             in1_ready_o,
    output logic             out_valid_o,
    output logic [WIDTH-1:0] out_data_o,
    input  logic             out_ready_i,
    output logic             sel_o
);

    localparam int unsigned CNT_W = $clog2(MAX_BURST + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_BURST);

    logic             sel_q, sel_d;
    logic [CNT_W-1:0] burst_q, burst_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;

    logic load_c;
    logic gnt_c;
    logic g_c;

    // Grant: owner keeps the channel until its burst saturates under contention.
    always_comb begin
        load_c = ~out_valid_q | out_ready_i;
        gnt_c  = 1'b0;
        g_c    = 1'b0;
        if (load_c) begin
            if (in0_valid_i && in1_valid_i) begin
                gnt_c = 1'b1;
                g_c   = (burst_q < CNT_MAX) ? sel_q : ~sel_q;
            end else if (in1_valid_i) begin
                gnt_c = 1'b1;
                g_c   = 1'b1;
            end else if (in0_valid_i) begin
                gnt_c = 1'b1;
                g_c   = 1'b0;
            end
        end
    end

    assign in0_ready_o = gnt_c & ~g_c & ~rst_i;
    assign in1_ready_o = gnt_c &  g_c & ~rst_i;

    // A grant always implies the granted requester is valid, so a grant is a transfer.
    always_comb begin
        sel_d       = sel_q;
        burst_d     = burst_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        if (gnt_c) begin
            out_valid_d = 1'b1;
            out_data_d  = g_c ? in1_data_i : in0_data_i;
            if (g_c == sel_q) begin
                burst_d = (burst_q == CNT_MAX) ? burst_q : burst_q + CNT_W'(1);
            end else begin
                sel_d   = g_c;
                burst_d = CNT_W'(1);
            end
        end else if (out_ready_i) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sel_q       <= 1'b0;
            burst_q     <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            sel_q       <= sel_d;
            burst_q     <= burst_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

    assign out_valid_o = out_valid_q;
    assign out_data_o  = out_data_q;
    assign sel_o       = sel_q;

endmodule

// File: tb/tb_mux2x1_rr_arbiter.sv
// Directed bench: a vector table on a MAX_BURST=4 instance, then an alternation
// sequence on a MAX_BURST=1 instance.
module tb_mux2x1_rr_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, v0, v1, ordy;
    logic [7:0] d0, d1;
    logic       r0, r1, ov, sel;
    logic [7:0] od;

    logic       rst2, v0b, v1b, ordyb;
    logic [7:0] d0b, d1b;
    logic       r0b, r1b, ovb, selb;
    logic [7:0] odb;

    mux2x1_rr_arbiter #(.WIDTH(8), .MAX_BURST(4)) dut (
        .clk_i(clk), .rst_i(rst),
        .in0_valid_i(v0), .in0_data_i(d0), .in0_ready_o(r0),
        .in1_valid_i(v1), .in1_data_i(d1), .in1_ready_o(r1),
        .out_valid_o(ov), .out_data_o(od), .out_ready_i(ordy), .sel_o(sel)
    );

    mux2x1_rr_arbiter #(.WIDTH(8), .MAX_BURST(1)) dut_alt (
        .clk_i(clk), .rst_i(rst2),
        .in0_valid_i(v0b), .in0_data_i(d0b), .in0_ready_o(r0b),
        .in1_valid_i(v1b), .in1_data_i(d1b), .in1_ready_o(r1b),
        .out_valid_o(ovb), .out_data_o(odb), .out_ready_i(ordyb), .sel_o(selb)
    );

    typedef struct {
        logic       rst;
        logic       v0;
        logic [7:0] d0;
        logic       v1;
        logic [7:0] d1;
        logic       ordy;
        logic       r0;
        logic       r1;
        logic       ov;
        logic [7:0] od;
        logic       sel;
    } vec_t;

    vec_t tbl[$];
    int   n_chk  = 0;
    int   n_pass = 0;

    task automatic add(input logic rst_v, input logic v0_v, input logic [7:0] d0_v,
                       input logic v1_v, input logic [7:0] d1_v, input logic ordy_v,
                       input logic r0_v, input logic r1_v, input logic ov_v,
                       input logic [7:0] od_v, input logic sel_v);
        vec_t e;
        e.rst = rst_v; e.v0 = v0_v; e.d0 = d0_v; e.v1 = v1_v; e.d1 = d1_v;
        e.ordy = ordy_v; e.r0 = r0_v; e.r1 = r1_v; e.ov = ov_v; e.od = od_v;
        e.sel = sel_v;
        tbl.push_back(e);
    endtask

    task automatic check(input string name, input int idx, input logic [7:0] act,
                         input logic [7:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s step %0d: got %h expected %h", name, idx, act, exp);
    endtask

    initial begin
        // rst v0 d0 v1 d1 ordy | r0 r1 ov od sel
        for (int i = 0; i < 3; i++) add(1, 1, 8'hA0, 1, 8'hB0, 1, 0, 0, 0, 8'h00, 0);
        for (int i = 0; i < 8; i++)
            add(0, 1, 8'(8'h10 + i), 0, 8'h00, 1, 1, 0, (i > 0),
                (i > 0) ? 8'(8'h0F + i) : 8'h00, 0);
        add(0, 1, 8'hA0, 1, 8'hB0, 1, 0, 1, 1, 8'h17, 0);
        add(0, 1, 8'hA0, 1, 8'hB1, 1, 0, 1, 1, 8'hB0, 1);
        add(0, 1, 8'hA0, 1, 8'hB2, 1, 0, 1, 1, 8'hB1, 1);
        add(0, 1, 8'hA0, 1, 8'hB3, 1, 0, 1, 1, 8'hB2, 1);
        add(0, 1, 8'hA0, 1, 8'hB4, 1, 1, 0, 1, 8'hB3, 1);
        add(0, 1, 8'hA1, 1, 8'hB4, 1, 1, 0, 1, 8'hA0, 0);
        add(0, 1, 8'hA2, 1, 8'hB4, 1, 1, 0, 1, 8'hA1, 0);
        add(0, 1, 8'hA3, 1, 8'hB4, 1, 1, 0, 1, 8'hA2, 0);
        add(0, 1, 8'hA4, 1, 8'hB4, 1, 0, 1, 1, 8'hA3, 0);
        add(0, 1, 8'hA4, 1, 8'hB5, 1, 0, 1, 1, 8'hB4, 1);
        for (int i = 0; i < 3; i++) add(0, 1, 8'hA4, 1, 8'hB6, 0, 0, 0, 1, 8'hB5, 1);
        add(0, 1, 8'hA4, 1, 8'hB6, 1, 0, 1, 1, 8'hB5, 1);
        add(0, 1, 8'hA4, 1, 8'hB7, 1, 0, 1, 1, 8'hB6, 1);
        add(0, 1, 8'hA4, 1, 8'hB8, 1, 1, 0, 1, 8'hB7, 1);
        add(0, 0, 8'h00, 0, 8'h00, 1, 0, 0, 1, 8'hA4, 0);
        add(0, 0, 8'h00, 0, 8'h00, 1, 0, 0, 0, 8'hA4, 0);
        add(0, 0, 8'h00, 0, 8'h00, 0, 0, 0, 0, 8'hA4, 0);
        add(0, 0, 8'h00, 1, 8'hB8, 1, 0, 1, 0, 8'hA4, 0);
        add(0, 0, 8'h00, 1, 8'hB9, 1, 0, 1, 1, 8'hB8, 1);
        add(1, 1, 8'hA5, 1, 8'hBA, 0, 0, 0, 1, 8'hB9, 1);
        add(0, 1, 8'hA5, 1, 8'hBA, 1, 1, 0, 0, 8'h00, 0);
        add(0, 0, 8'h00, 0, 8'h00, 1, 0, 0, 1, 8'hA5, 0);
        add(0, 0, 8'h00, 0, 8'h00, 1, 0, 0, 0, 8'hA5, 0);

        rst = 1; v0 = 1; v1 = 1; d0 = 8'hA0; d1 = 8'hB0; ordy = 1;
        rst2 = 1; v0b = 0; v1b = 0; d0b = 8'h00; d1b = 8'h00; ordyb = 1;
        @(posedge clk); #1;

        foreach (tbl[k]) begin
            rst = tbl[k].rst; v0 = tbl[k].v0; d0 = tbl[k].d0;
            v1 = tbl[k].v1; d1 = tbl[k].d1; ordy = tbl[k].ordy;
            @(negedge clk);
            check("in0_ready", k, 8'(r0), 8'(tbl[k].r0));
            check("in1_ready", k, 8'(r1), 8'(tbl[k].r1));
            check("out_valid", k, 8'(ov), 8'(tbl[k].ov));
            check("out_data", k, od, tbl[k].od);
            check("sel", k, 8'(sel), 8'(tbl[k].sel));
            @(posedge clk); #1;
        end

        // MAX_BURST=1: strict alternation starting with in0
        begin
            int i0, i1;
            i0 = 0; i1 = 0;
            rst2 = 0; v0b = 1; v1b = 1; ordyb = 1;
            for (int k = 0; k < 10; k++) begin
                d0b = 8'(8'hA0 + i0);
                d1b = 8'(8'hB0 + i1);
                @(negedge clk);
                check("alt_in0_ready", k, 8'(r0b), 8'((k % 2) == 0));
                check("alt_in1_ready", k, 8'(r1b), 8'((k % 2) == 1));
                if (k == 0) begin
                    check("alt_out_valid", k, 8'(ovb), 8'h00);
                    check("alt_out_data", k, odb, 8'h00);
                end else begin
                    check("alt_out_valid", k, 8'(ovb), 8'h01);
                    check("alt_out_data", k, odb,
                          ((k - 1) % 2 == 0) ? 8'(8'hA0 + (k - 1) / 2) : 8'(8'hB0 + (k - 1) / 2));
                    check("alt_sel", k, 8'(selb), 8'((k - 1) % 2));
                end
                if (r0b) i0++;
                if (r1b) i1++;
                @(posedge clk); #1;
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/mux2x1_rr_arbiter.md
# mux2x1_rr_arbiter

- Two-requester arbiter and registered 2:1 data mux.
- Shares one output channel between request ports 0 and 1 using valid/ready handshakes.
- Grants are round-robin with a bounded burst length.
- The selected word is registered into a single-entry output stage. The `sel` output exposes the current owner so downstream logic and debug can see which input holds the channel.

## Interface
- WIDTH, 8, data width of each input and of the output.
- MAX_BURST, 4, maximum consecutive transfers one requester may make while the other is waiting. Legal range 1..15.
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in0_valid  input  1  requester 0 has a word.
- in0_data  input  WIDTH  requester 0 word.
- in0_ready  output  1  requester 0 word is accepted this cycle.
- in1_valid  input  1  requester 1 has a word.
- in1_data  input  WIDTH  requester 1 word.
- in1_ready  output  1  requester 1 word is accepted this cycle.
- out_valid  output  1  output register holds a word.
- out_data  output  WIDTH  output word.
- out_ready  input  1  consumer accepts the output word.
- sel  output  1  current owner (0 = in0, 1 = in1), registered.

## Operation
- State:
  - `sel` (owner).
  - `burst_cnt`, width $clog2(MAX_BURST+1), saturating at MAX_BURST.
  - `out_valid` and `out_data` (output register).
- Load slot: `load = ~out_valid | out_ready`.
- Grant `g` is combinational and evaluated only when `load` = 1:
  - Neither valid: no grant.
  - Only inN valid: `g` = N.
  - Both valid and `burst_cnt` < MAX_BURST: `g` = `sel` (owner keeps the channel).
  - Both valid and `burst_cnt` = MAX_BURST: `g` = ~`sel` (forced switch).
- Ready outputs:
  - `inN_ready` = `load` & (grant exists) & (`g` = N).
  - At most one `inN_ready` is high per cycle.
  - `inN_ready` may depend combinationally on both `in*_valid` and on `out_ready`.
- Transfer occurs when the granted `inN_valid` & `inN_ready` are both high:
  - `out_data` <= `g` ? `in1_data` : `in0_data`.
  - `out_valid` <= 1.
  - If `g` = `sel`: `burst_cnt` <= min(`burst_cnt`+1, MAX_BURST).
  - Else: `sel` <= `g`, `burst_cnt` <= 1.
- No transfer and `out_ready` = 1: `out_valid` <= 0; `out_data` holds its last value.
- No transfer and `out_ready` = 0: output register holds. `out_data` must not change while `out_valid` = 1 and `out_ready` = 0.
- Idle cycles (no valid input) do not change `sel` or `burst_cnt`.
- Effect of MAX_BURST:
  - MAX_BURST = 1 gives strict alternation under contention.
  - A lone requester streams indefinitely. Its `burst_cnt` saturates, so a newly arriving competitor is granted on its first cycle of contention.
- Reset (`rst` = 1 at a clock edge), regardless of traffic:
  - `sel` = 0, `burst_cnt` = 0, `out_valid` = 0, `out_data` = 0.
  - `in0_ready` = `in1_ready` = 0 during reset.
  - Any word held in the output register is discarded.

## Timing
- Latency: a word accepted at edge N is presented on `out_valid`/`out_data` from edge N (visible in cycle N+1).
- Throughput: one word per cycle while `out_ready` = 1.
- Backpressure: `out_ready` = 0 with `out_valid` = 1 forces both `inN_ready` low in the same cycle.
- Simultaneous drain and load (`out_valid` = 1, `out_ready` = 1, transfer) replaces the word with no bubble.
- `sel` and `burst_cnt` update on the same edge as the transfer. Grant in the next cycle uses the updated values.
- First cycle after reset deasserts: grant evaluation is live. With both valid and `burst_cnt` = 0 < MAX_BURST, `g` = 0.

## Test plan
- Reset values:
  - Stimulus: hold `rst` high 3 cycles with both valid and `out_ready` = 1.
  - Required: `out_valid` = 0, `out_data` = 0, `sel` = 0, both ready low throughout. Release reset: `in0_ready` = 1 on the first cycle.
- Single requester streaming:
  - Stimulus: only in0 valid, data 0x10..0x17, `out_ready` = 1.
  - Required: `out_data` shows 0x10..0x17 on 8 consecutive cycles, one cycle after each accept. `sel` stays 0. `burst_cnt` saturates at 4.
- Contention, MAX_BURST = 4:
  - Stimulus: both valid continuously; in0 sends 0xA0.., in1 sends 0xB0.., `out_ready` = 1.
  - Required: accept order is four in0 words, four in1 words, four in0 words, with `out_data` A0 A1 A2 A3 B0 B1 B2 B3 A4 …. `sel` toggles on every fourth transfer.
- Backpressure:
  - Stimulus: while streaming, drop `out_ready` for 3 cycles.
  - Required: `out_data` is stable and `out_valid` = 1 during the stall, both `inN_ready` = 0, and no word is lost or duplicated after `out_ready` returns.
- Strict alternation, MAX_BURST = 1:
  - Stimulus: both requesters valid continuously.
  - Required: `out_data` alternates in0/in1 every cycle, starting with in0.
- Reset mid-burst:
  - Stimulus: assert `rst` for one cycle after in1 has made 2 transfers and `out_valid` = 1.
  - Required: next cycle `out_valid` = 0, `sel` = 0, `burst_cnt` = 0. With both valid afterwards, in0 wins first.
